uart_tx_async: RTL and testbench

Serial transmitter for the CoreUART wrapper. It is the transmit-side counterpart of the asynchronous receiver. It accepts bytes from the host interface through a single holding register and serialises them on TX as start / 7-or-8 data (LSB first) / optional parity / stop. Each bit lasts OVERSAMPLE baud-enable pulses, and the frame configuration matches the receiver so one baud generator and one control register drive both.

---
 rtl/uart_tx_async.sv | 156 +++++++++++++++
 tb/tb_uart_tx_async.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_async.sv
// uart_tx_async: CoreUART transmitter. One holding register feeds a shift
// register; each frame is start / 7 or 8 data bits LSB first / optional
// parity / STOP_BITS stop bits, every bit lasting OVERSAMPLE BAUD_EN pulses.
// All outputs are taken straight from flops.
module uart_tx_async #(
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       BAUD_EN,
  input  logic       BIT8,
  input  logic       PARITY_EN,
  input  logic       ODD_N_EVEN,
  input  logic [7:0] TX_DATA,
  input  logic       WEN,
  output logic       TX,
  output logic       TXRDY,
  output logic       TX_BUSY,
  output logic       FRAME_DONE
);

  localparam int            TW        = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    hold_q, hold_d;
  logic          hold_full_q, hold_full_d;
  logic [7:0]    shift_q, shift_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;       // data-bit index, reused as stop-bit index
  logic          bit8_q, bit8_d;
  logic          par_en_q, par_en_d;
  logic          par_q, par_d;       // parity bit, precomputed at transfer
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          bit_end;
  logic          xfer;

  // Next-state logic: FSM, counters, holding register and registered outputs.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    bit8_d      = bit8_q;
    par_en_d    = par_en_q;
    par_d       = par_q;
    done_d      = 1'b0;
    xfer        = 1'b0;
    bit_end     = BAUD_EN && (tick_q == TICK_LAST);

    if (state_q != S_IDLE && BAUD_EN)
      tick_d = bit_end ? '0 : tick_q + 1'b1;

    case (state_q)
      S_IDLE:   xfer = hold_full_q;
      S_START:  if (bit_end) state_d = S_DATA;
      S_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == (bit8_q ? 3'd7 : 3'd6)) begin
            bit_d   = 3'd0;
            state_d = par_en_q ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      S_PARITY: if (bit_end) state_d = S_STOP;
      S_STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
            xfer    = hold_full_q;   // back-to-back: no idle cell
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default:  state_d = S_IDLE;
    endcase

    // Transfer: frame config is frozen here for the whole frame.
    if (xfer) begin
      state_d     = S_START;
      shift_d     = hold_q;
      hold_full_d = 1'b0;
      tick_d      = '0;
      bit_d       = 3'd0;
      bit8_d      = BIT8;
      par_en_d    = PARITY_EN;
      par_d       = (^(hold_q & {BIT8, 7'h7f})) ^ ODD_N_EVEN;
    end

    // Writes only land in an empty holding register; others are dropped.
    if (WEN && !hold_full_q) begin
      hold_d      = TX_DATA;
      hold_full_d = 1'b1;
    end

    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State register with synchronous active-low reset; reset aborts any frame.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q     <= S_IDLE;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      shift_q     <= 8'h00;
      tick_q      <= '0;
      bit_q       <= 3'd0;
      bit8_q      <= 1'b1;
      par_en_q    <= 1'b0;
      par_q       <= 1'b0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      bit8_q      <= bit8_d;
      par_en_q    <= par_en_d;
      par_q       <= par_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign TX         = tx_q;
  assign TXRDY      = ~hold_full_q;
  assign TX_BUSY    = busy_q;
  assign FRAME_DONE = done_q;

endmodule

// File: tb/tb_uart_tx_async.sv
// Bench for uart_tx_async: two instances (1 and 2 stop bits) share stimulus.
// A cell-list model predicts TX/TXRDY/TX_BUSY/FRAME_DONE every cycle, and
// directed frames are pinned against hand-computed cell strings and timings.
module tb_uart_tx_async;
  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       RESET_N, BAUD_EN, BIT8, PARITY_EN, ODD_N_EVEN, WEN;
  logic [7:0] TX_DATA;
  logic [1:0] tx_o, rdy_o, busy_o, done_o;

  int vectors = 0;
  int miscompares = 0;
  int baud_div = 1;
  int bcnt = 0;

  always #5 clk = ~clk;

  uart_tx_async #(.OVERSAMPLE(OS), .STOP_BITS(1)) u_dut_s1 (
    .CLK(clk), .RESET_N(RESET_N), .BAUD_EN(BAUD_EN), .BIT8(BIT8),
    .PARITY_EN(PARITY_EN), .ODD_N_EVEN(ODD_N_EVEN), .TX_DATA(TX_DATA),
    .WEN(WEN), .TX(tx_o[0]), .TXRDY(rdy_o[0]), .TX_BUSY(busy_o[0]),
    .FRAME_DONE(done_o[0]));

  uart_tx_async #(.OVERSAMPLE(OS), .STOP_BITS(2)) u_dut_s2 (
    .CLK(clk), .RESET_N(RESET_N), .BAUD_EN(BAUD_EN), .BIT8(BIT8),
    .PARITY_EN(PARITY_EN), .ODD_N_EVEN(ODD_N_EVEN), .TX_DATA(TX_DATA),
    .WEN(WEN), .TX(tx_o[1]), .TXRDY(rdy_o[1]), .TX_BUSY(busy_o[1]),
    .FRAME_DONE(done_o[1]));

  // Model: each frame is a list of cell values; a cell retires after OS
  // baud pulses counted from the transfer edge.
  bit         m_valid = 1'b0;
  bit         m_full[2], m_busy[2], m_tx[2], m_done[2];
  logic [7:0] m_hold[2];
  int         m_cnt[2], m_pos[2], m_len[2];
  bit         m_cell[2][12];
  bit         old_full, p;
  int         nb;

  // Model update on each rising edge using the inputs set up half a cycle earlier.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      old_full  = m_full[d];
      m_done[d] = 1'b0;
      if (!RESET_N) begin
        m_full[d] = 1'b0; m_busy[d] = 1'b0; m_tx[d] = 1'b1;
        m_cnt[d] = 0; m_pos[d] = 0; m_len[d] = 0;
        m_valid = 1'b1;
      end else begin
        if (m_busy[d] && BAUD_EN) begin
          m_cnt[d] = m_cnt[d] + 1;
          if (m_cnt[d] == OS) begin
            m_cnt[d] = 0;
            m_pos[d] = m_pos[d] + 1;
            if (m_pos[d] == m_len[d]) begin
              m_busy[d] = 1'b0;
              m_done[d] = 1'b1;
            end
          end
        end
        if (!m_busy[d] && old_full) begin
          nb = BIT8 ? 8 : 7;
          p  = ODD_N_EVEN;
          m_cell[d][0] = 1'b0;
          for (int i = 0; i < nb; i++) begin
            m_cell[d][1+i] = m_hold[d][i];
            p = p ^ m_hold[d][i];
          end
          m_len[d] = 1 + nb;
          if (PARITY_EN) begin
            m_cell[d][m_len[d]] = p;
            m_len[d] = m_len[d] + 1;
          end
          for (int s = 0; s <= d; s++) begin
            m_cell[d][m_len[d]] = 1'b1;
            m_len[d] = m_len[d] + 1;
          end
          m_full[d] = 1'b0;
          m_busy[d] = 1'b1;
          m_cnt[d]  = 0;
          m_pos[d]  = 0;
        end
        if (WEN && !old_full) begin
          m_full[d] = 1'b1;
          m_hold[d] = TX_DATA;
        end
        m_tx[d] = m_busy[d] ? m_cell[d][m_pos[d]] : 1'b1;
      end
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk_s(input string nm, input string got, input string exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got cells %s, expected %s", nm, got, exp);
    end
  endtask

  // One cycle: sample at the falling edge, compare with model, advance baud.
  task automatic step();
    @(negedge clk);
    if (m_valid) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("tx%0d", d),   tx_o[d],   m_tx[d]);
        chk($sformatf("rdy%0d", d),  rdy_o[d],  !m_full[d]);
        chk($sformatf("busy%0d", d), busy_o[d], m_busy[d]);
        chk($sformatf("done%0d", d), done_o[d], m_done[d]);
      end
    end
    bcnt++;
    BAUD_EN = (bcnt % baud_div == 0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      if (busy_o == 2'b00 && rdy_o == 2'b11) break;
      step();
    end
    chk("wait_idle", {busy_o, rdy_o}, 4'b0011);
  endtask

  // Send one byte with BAUD_EN every cycle; sample mid-cell from the transfer.
  task automatic run_frame(input int d, input logic [7:0] data, input bit b8,
                           input bit pe, input bit odd, input string exp,
                           input int exp_done, input string nm);
    string got;
    int    dc;
    wait_idle();
    BIT8 = b8; PARITY_EN = pe; ODD_N_EVEN = odd; TX_DATA = data; WEN = 1'b1;
    step();
    WEN = 1'b0;
    step();
    got = "";
    dc  = -1;
    for (int c = 0; c <= exp_done + 16; c++) begin
      if (c % OS == OS / 2 && got.len() < exp.len())
        got = $sformatf("%s%0d", got, tx_o[d]);
      if (done_o[d] && dc < 0) dc = c;
      step();
    end
    chk_s(nm, got, exp);
    chk({nm, "_done"}, dc, exp_done);
  endtask

  initial begin
    string got;
    int    d1, d2, lo, dc;
    RESET_N = 1'b0; WEN = 1'b0; BIT8 = 1'b1; PARITY_EN = 1'b0;
    ODD_N_EVEN = 1'b0; TX_DATA = 8'h00; BAUD_EN = 1'b1;
    repeat (3) step();
    chk("reset_tx",   tx_o,   2'b11);
    chk("reset_rdy",  rdy_o,  2'b11);
    chk("reset_busy", busy_o, 2'b00);
    chk("reset_done", done_o, 2'b00);
    RESET_N = 1'b1;
    step();

    // Reset in the middle of 0x55 with a second byte parked in the holding reg.
    BIT8 = 1'b1; PARITY_EN = 1'b0; TX_DATA = 8'h55; WEN = 1'b1;
    step();
    WEN = 1'b0;
    repeat (5) step();
    TX_DATA = 8'h77; WEN = 1'b1;
    step();
    WEN = 1'b0;
    repeat (40) step();
    chk("pre_rst_busy", busy_o[0], 1);
    chk("pre_rst_rdy",  rdy_o[0],  0);
    RESET_N = 1'b0;
    step();
    chk("rst_tx",   tx_o[0],   1);
    chk("rst_rdy",  rdy_o[0],  1);
    chk("rst_busy", busy_o[0], 0);
    RESET_N = 1'b1;
    repeat (20) step();
    chk("rst_discard", busy_o, 2'b00);
    run_frame(0, 8'h00, 1'b1, 1'b0, 1'b0, "0000000001", 160, "clean_00");

    run_frame(0, 8'hA5, 1'b1, 1'b1, 1'b0, "01010010101", 176, "8E1_A5");
    run_frame(0, 8'hA5, 1'b1, 1'b1, 1'b1, "01010010111", 176, "8O1_A5");
    run_frame(1, 8'hC1, 1'b0, 1'b0, 1'b0, "0100000111",  160, "7N2_C1");

    // Back-to-back 8N1: 0x01 then 0x80; a write while full (0x33) is dropped.
    wait_idle();
    BIT8 = 1'b1; PARITY_EN = 1'b0; TX_DATA = 8'h01; WEN = 1'b1;
    step();
    WEN = 1'b0;
    step();
    got = ""; d1 = -1; d2 = -1;
    for (int c = 0; c <= 340; c++) begin
      if (c % OS == OS / 2 && c < 320) got = $sformatf("%s%0d", got, tx_o[0]);
      if (done_o[0] && c < 200 && d1 < 0) d1 = c;
      if (done_o[0] && c >= 200 && d2 < 0) d2 = c;
      if (c == 160) begin
        chk("b2b_gap_tx",   tx_o[0],   0);
        chk("b2b_gap_busy", busy_o[0], 1);
      end
      if (c == 5) begin TX_DATA = 8'h80; WEN = 1'b1; end
      if (c == 6) WEN = 1'b0;
      if (c == 20) begin
        chk("b2b_full_rdy", rdy_o[0], 0);
        TX_DATA = 8'h33; WEN = 1'b1;
      end
      if (c == 21) WEN = 1'b0;
      step();
    end
    chk_s("b2b_cells", got, "01000000010000000011");
    chk("b2b_done1", d1, 160);
    chk("b2b_done2", d2, 320);
    chk("b2b_drop",  busy_o[0], 0);

    // BAUD_EN every third cycle, 8N1 0xFF: non-start bits are 48 cycles each.
    wait_idle();
    baud_div = 3;
    BIT8 = 1'b1; PARITY_EN = 1'b0; TX_DATA = 8'hFF; WEN = 1'b1;
    step();
    WEN = 1'b0;
    step();
    lo = 0; dc = -1;
    for (int c = 0; c < 700; c++) begin
      if (!tx_o[0]) lo++;
      if (done_o[0]) begin
        dc = c;
        chk("b3_busy_at_done", busy_o[0], 0);
        chk("b3_tx_at_done",   tx_o[0],   1);
        break;
      end
      step();
    end
    chk("b3_start_len_ok", (lo >= 46 && lo <= 48), 1);
    chk("b3_tail_len", dc - lo, 432);
    baud_div = 1;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
